// File: rtl/dcache_wb2_pkg.sv
// Shared types and helpers for the two-way write-back data cache.
// Address-field widths are derived here so every file agrees on the split.
package dcache_wb2_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WB        = 3'd1;
  localparam logic [2:0] ST_FILL_REQ  = 3'd2;
  localparam logic [2:0] ST_FILL_WAIT = 3'd3;
  localparam logic [2:0] ST_RESP      = 3'd4;
  localparam logic [2:0] ST_FL_SCAN   = 3'd5;
  localparam logic [2:0] ST_FL_WB     = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_WB        = ST_WB,
    S_FILL_REQ  = ST_FILL_REQ,
    S_FILL_WAIT = ST_FILL_WAIT,
    S_RESP      = ST_RESP,
    S_FL_SCAN   = ST_FL_SCAN,
    S_FL_WB     = ST_FL_WB
  } state_e;

  function automatic int off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int data_w, input int sets);
    return addr_w - idx_w(sets) - off_w(data_w);
  endfunction

  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       strb);
    return strb ? new_b : old_b;
  endfunction

endpackage

// File: rtl/dcache_wb2_if.sv
// CPU-side and memory-side buses of the data cache.
// master drives requests; the cache is slave on the CPU bus and master on memory.
interface dcache_wb2_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_W-1:0]     req_addr;
  logic                  req_we;
  logic [DATA_W/8-1:0]   req_wstrb;
  logic [DATA_W-1:0]     req_wdata;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_hit;
  logic                  flush;
  logic                  flush_done;

  modport master (
    output req_valid, req_addr, req_we, req_wstrb, req_wdata, flush,
    input  req_ready, rsp_valid, rsp_rdata, rsp_hit, flush_done
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wstrb, req_wdata, flush,
    output req_ready, rsp_valid, rsp_rdata, rsp_hit, flush_done
  );
endinterface

interface dcache_wb2_mem_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_rdata;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/dcache_wb2_way.sv
// One cache way: valid/dirty/tag/data per set, combinational read at i_idx.
// A line write always sets valid; i_clr_en only clears dirty (used by flush).
module dcache_wb2_way
  import dcache_wb2_pkg::*;
#(
  parameter  int SETS   = 32,
  parameter  int TAG_W  = 9,
  parameter  int DATA_W = 32,
  localparam int IDX_W  = idx_w(SETS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic              i_wr_en,
  input  logic              i_wr_dirty,
  input  logic [TAG_W-1:0]  i_wr_tag,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_clr_en,
  output logic              o_hit,
  output logic              o_valid,
  output logic              o_dirty,
  output logic [TAG_W-1:0]  o_tag,
  output logic [DATA_W-1:0] o_data
);

  logic [SETS-1:0]   r_valid;
  logic [SETS-1:0]   r_dirty;
  logic [TAG_W-1:0]  r_tag  [SETS];
  logic [DATA_W-1:0] r_data [SETS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_wr_en) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= i_wr_dirty;
    end else if (i_clr_en) begin
      r_dirty[i_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_idx]  <= i_wr_tag;
      r_data[i_idx] <= i_wr_data;
    end
  end

  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_data  = r_data[i_idx];
  assign o_hit   = o_valid && (r_tag[i_idx] == i_tag);

endmodule

// File: rtl/dcache_wb2.sv
// Two-way set-associative write-back, write-allocate data cache, one word per line.
// Single outstanding request; flush walks every (set, way) writing back dirty lines.
module dcache_wb2
  import dcache_wb2_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int SETS   = 32
) (
  input  logic              clk,
  input  logic              rst,
  dcache_wb2_if.slave       cpu,
  dcache_wb2_mem_if.master  mem
);

  localparam int OFF_W  = off_w(DATA_W);
  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = tag_w(ADDR_W, DATA_W, SETS);
  localparam int STRB_W = DATA_W / 8;

  state_e              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [TAG_W-1:0]    r_tag;
  logic                r_we;
  logic [STRB_W-1:0]   r_wstrb;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_victim;
  logic                r_hit;
  logic [DATA_W-1:0]   r_rdata;
  logic [SETS-1:0]     r_lru;
  logic [IDX_W-1:0]    r_scan_set;
  logic                r_scan_way;

  logic [IDX_W-1:0]    w_req_idx;
  logic [TAG_W-1:0]    w_req_tag;
  logic [IDX_W-1:0]    w_idx;
  logic [TAG_W-1:0]    w_cmp_tag;
  logic                w_idle;
  logic                w_flushing;
  logic [1:0]          w_hit;
  logic [1:0]          w_valid;
  logic [1:0]          w_dirty;
  logic [TAG_W-1:0]    w_tag  [2];
  logic [DATA_W-1:0]   w_data [2];
  logic                w_any_hit;
  logic                w_hit_way;
  logic                w_miss_victim;
  logic                w_sel;
  logic                w_accept;
  logic                w_fill;
  logic                w_last;
  logic                w_scan_dirty;
  logic                w_fl_ack;
  logic [DATA_W-1:0]   w_merge_old;
  logic [DATA_W-1:0]   w_merge_new;
  logic [STRB_W-1:0]   w_merge_strb;
  logic [DATA_W-1:0]   w_merged;
  logic [1:0]          w_wr_en;
  logic [1:0]          w_clr_en;
  logic                w_wr_dirty;
  logic [TAG_W-1:0]    w_wr_tag;
  logic [DATA_W-1:0]   w_wr_data;
  logic                w_mem_valid;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;

  assign w_req_idx  = cpu.req_addr[OFF_W +: IDX_W];
  assign w_req_tag  = cpu.req_addr[ADDR_W-1 -: TAG_W];
  assign w_idle     = (r_state == S_IDLE);
  assign w_flushing = (r_state == S_FL_SCAN) || (r_state == S_FL_WB);

  // Arrays are addressed by the live request in IDLE, the scan pointer while
  // flushing, and the latched request otherwise.
  assign w_idx     = w_idle ? w_req_idx : (w_flushing ? r_scan_set : r_idx);
  assign w_cmp_tag = w_idle ? w_req_tag : r_tag;

  dcache_wb2_way #(.SETS(SETS), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_way0 (
    .clk(clk), .rst(rst), .i_idx(w_idx), .i_tag(w_cmp_tag),
    .i_wr_en(w_wr_en[0]), .i_wr_dirty(w_wr_dirty), .i_wr_tag(w_wr_tag),
    .i_wr_data(w_wr_data), .i_clr_en(w_clr_en[0]),
    .o_hit(w_hit[0]), .o_valid(w_valid[0]), .o_dirty(w_dirty[0]),
    .o_tag(w_tag[0]), .o_data(w_data[0])
  );

  dcache_wb2_way #(.SETS(SETS), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_way1 (
    .clk(clk), .rst(rst), .i_idx(w_idx), .i_tag(w_cmp_tag),
    .i_wr_en(w_wr_en[1]), .i_wr_dirty(w_wr_dirty), .i_wr_tag(w_wr_tag),
    .i_wr_data(w_wr_data), .i_clr_en(w_clr_en[1]),
    .o_hit(w_hit[1]), .o_valid(w_valid[1]), .o_dirty(w_dirty[1]),
    .o_tag(w_tag[1]), .o_data(w_data[1])
  );

  assign w_any_hit     = |w_hit;
  assign w_hit_way     = !w_hit[0];
  assign w_miss_victim = !w_valid[0] ? 1'b0 : (!w_valid[1] ? 1'b1 : r_lru[w_req_idx]);
  assign w_sel         = w_flushing ? r_scan_way : r_victim;
  assign w_accept      = w_idle && cpu.req_valid && !cpu.flush;
  assign w_fill        = (r_state == S_FILL_WAIT) && mem.mem_rsp_valid;
  assign w_last        = (r_scan_set == IDX_W'(SETS - 1)) && r_scan_way;
  assign w_scan_dirty  = w_valid[r_scan_way] && w_dirty[r_scan_way];
  assign w_fl_ack      = (r_state == S_FL_WB) && mem.mem_req_ready;

  assign w_merge_old  = w_idle ? w_data[w_hit_way] : mem.mem_rsp_rdata;
  assign w_merge_new  = w_idle ? cpu.req_wdata : r_wdata;
  assign w_merge_strb = w_idle ? cpu.req_wstrb : r_wstrb;

  always_comb begin
    w_merged = w_merge_old;
    for (int unsigned b = 0; b < STRB_W; b++) begin
      w_merged[8*b +: 8] = merge_byte(w_merge_old[8*b +: 8], w_merge_new[8*b +: 8],
                                      w_merge_strb[b]);
    end
  end

  always_comb begin
    w_wr_en    = '0;
    w_clr_en   = '0;
    w_wr_dirty = 1'b0;
    w_wr_tag   = w_req_tag;
    w_wr_data  = w_merged;
    if (w_accept && w_any_hit && cpu.req_we) begin
      w_wr_en[w_hit_way] = 1'b1;
      w_wr_dirty         = 1'b1;
    end
    if (w_fill) begin
      w_wr_en[r_victim] = 1'b1;
      w_wr_dirty        = r_we;
      w_wr_tag          = r_tag;
      w_wr_data         = r_we ? w_merged : mem.mem_rsp_rdata;
    end
    if (w_fl_ack) begin
      w_clr_en[r_scan_way] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_tag      <= '0;
      r_we       <= 1'b0;
      r_wstrb    <= '0;
      r_wdata    <= '0;
      r_victim   <= 1'b0;
      r_hit      <= 1'b0;
      r_rdata    <= '0;
      r_lru      <= '0;
      r_scan_set <= '0;
      r_scan_way <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cpu.flush) begin
            r_scan_set <= '0;
            r_scan_way <= 1'b0;
            r_state    <= S_FL_SCAN;
          end else if (cpu.req_valid) begin
            r_idx   <= w_req_idx;
            r_tag   <= w_req_tag;
            r_we    <= cpu.req_we;
            r_wstrb <= cpu.req_wstrb;
            r_wdata <= cpu.req_wdata;
            if (w_any_hit) begin
              r_hit            <= 1'b1;
              r_rdata          <= cpu.req_we ? '0 : w_data[w_hit_way];
              r_lru[w_req_idx] <= !w_hit_way;
              r_state          <= S_RESP;
            end else begin
              r_hit    <= 1'b0;
              r_victim <= w_miss_victim;
              r_state  <= (w_valid[w_miss_victim] && w_dirty[w_miss_victim]) ? S_WB : S_FILL_REQ;
            end
          end
        end
        S_WB:        if (mem.mem_req_ready) r_state <= S_FILL_REQ;
        S_FILL_REQ:  if (mem.mem_req_ready) r_state <= S_FILL_WAIT;
        S_FILL_WAIT: begin
          if (mem.mem_rsp_valid) begin
            r_rdata      <= r_we ? '0 : mem.mem_rsp_rdata;
            r_lru[r_idx] <= !r_victim;
            r_state      <= S_RESP;
          end
        end
        S_RESP: r_state <= S_IDLE;
        S_FL_SCAN, S_FL_WB: begin
          // A dirty entry detours through FL_WB and advances once its write is taken.
          if ((r_state == S_FL_SCAN && !w_scan_dirty) || w_fl_ack) begin
            if (w_last) r_state <= S_IDLE;
            else begin
              {r_scan_set, r_scan_way} <= {r_scan_set, r_scan_way} + 1'b1;
              r_state                  <= S_FL_SCAN;
            end
          end else if (r_state == S_FL_SCAN) begin
            r_state <= S_FL_WB;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_mem_valid = (r_state == S_WB) || (r_state == S_FILL_REQ) || (r_state == S_FL_WB);
  assign w_mem_we    = (r_state == S_WB) || (r_state == S_FL_WB);

  always_comb begin
    w_mem_addr = '0;
    if (w_mem_valid) begin
      w_mem_addr[ADDR_W-1 -: TAG_W] = w_mem_we ? w_tag[w_sel] : r_tag;
      w_mem_addr[OFF_W +: IDX_W]    = w_idx;
    end
  end

  assign mem.mem_req_valid = w_mem_valid;
  assign mem.mem_req_we    = w_mem_we;
  assign mem.mem_req_addr  = w_mem_addr;
  assign mem.mem_req_wdata = w_mem_we ? w_data[w_sel] : '0;

  assign cpu.req_ready  = !rst && w_idle && !cpu.flush;
  assign cpu.rsp_valid  = (r_state == S_RESP);
  assign cpu.rsp_rdata  = (r_state == S_RESP) ? r_rdata : '0;
  assign cpu.rsp_hit    = (r_state == S_RESP) && r_hit;
  assign cpu.flush_done = ((r_state == S_FL_SCAN) && w_last && !w_scan_dirty) ||
                          (w_fl_ack && w_last);

endmodule

// File: tb/tb_dcache_wb2.sv
// Directed bench for dcache_wb2 with a ready/valid memory model and an event log.
module tb_dcache_wb2;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NS = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_wb2_if     #(.ADDR_W(AW), .DATA_W(DW)) cif ();
  dcache_wb2_mem_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

  dcache_wb2 #(.ADDR_W(AW), .DATA_W(DW), .SETS(NS)) dut (
    .clk(clk), .rst(rst), .cpu(cif), .mem(mif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] data;
  } ev_t;

  ev_t         ev_q[$];
  logic [31:0] mem [int];
  int          ready_delay = 0;
  int          wait_cnt    = 0;
  int          stab_err    = 0;
  bit          hold_rsp    = 1'b0;
  bit          rsp_pend    = 1'b0;
  bit          prev_wait   = 1'b0;
  logic [31:0] rsp_data;
  logic [15:0] sv_addr;
  logic [31:0] sv_wdata;
  logic        sv_we;

  function automatic logic [31:0] mem_rd(input logic [15:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return {16'hA5A5, a};
  endfunction

  function automatic logic [31:0] ev_we(input int i);
    if (i < ev_q.size()) return {31'd0, ev_q[i].we};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ev_addr(input int i);
    if (i < ev_q.size()) return {16'd0, ev_q[i].addr};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ev_data(input int i);
    if (i < ev_q.size()) return ev_q[i].data;
    return 32'hFFFF_FFFF;
  endfunction

  // Memory slave: ready after ready_delay waiting cycles, refill data one cycle after the handshake.
  always @(negedge clk) begin
    mif.mem_rsp_valid = 1'b0;
    if (rst) begin
      rsp_pend          = 1'b0;
      mif.mem_req_ready = 1'b0;
      wait_cnt          = 0;
      prev_wait         = 1'b0;
    end else begin
      if (rsp_pend) begin
        mif.mem_rsp_valid = 1'b1;
        mif.mem_rsp_rdata = rsp_data;
        rsp_pend          = 1'b0;
      end
      if (mif.mem_req_valid) begin
        if (prev_wait && (mif.mem_req_addr !== sv_addr || mif.mem_req_wdata !== sv_wdata ||
                          mif.mem_req_we !== sv_we))
          stab_err++;
        sv_addr  = mif.mem_req_addr;
        sv_wdata = mif.mem_req_wdata;
        sv_we    = mif.mem_req_we;
        if (wait_cnt >= ready_delay) begin
          mif.mem_req_ready = 1'b1;
          wait_cnt          = 0;
          prev_wait         = 1'b0;
          ev_q.push_back('{mif.mem_req_we, mif.mem_req_addr, mif.mem_req_wdata});
          if (mif.mem_req_we) mem[int'(mif.mem_req_addr)] = mif.mem_req_wdata;
          else if (!hold_rsp) begin
            rsp_pend = 1'b1;
            rsp_data = mem_rd(mif.mem_req_addr);
          end
        end else begin
          mif.mem_req_ready = 1'b0;
          wait_cnt++;
          prev_wait = 1'b1;
        end
      end else begin
        mif.mem_req_ready = 1'b0;
        wait_cnt          = 0;
        prev_wait         = 1'b0;
      end
    end
  end

  task automatic wait_idle();
    int g = 0;
    @(negedge clk);
    while (!cif.req_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!cif.req_ready) chk("req_ready_timeout", 32'(cif.req_ready), 32'd1);
  endtask

  task automatic do_req(input logic [15:0] a, input logic we, input logic [3:0] st,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic [31:0] hit, output int lat);
    wait_idle();
    cif.req_valid = 1'b1;
    cif.req_addr  = a;
    cif.req_we    = we;
    cif.req_wstrb = st;
    cif.req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    cif.req_valid = 1'b0;
    lat = 1;
    while (!cif.rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!cif.rsp_valid) chk("rsp_timeout", 32'(cif.rsp_valid), 32'd1);
    rd  = cif.rsp_rdata;
    hit = 32'(cif.rsp_hit);
  endtask

  task automatic do_flush(output int lat);
    wait_idle();
    cif.flush     = 1'b1;
    cif.req_valid = 1'b1;
    cif.req_addr  = 16'h0040;
    cif.req_we    = 1'b0;
    #1 chk("flush_prio_ready", 32'(cif.req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    cif.flush     = 1'b0;
    cif.req_valid = 1'b0;
    lat = 1;
    while (!cif.flush_done && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk("flush_done_seen", 32'(cif.flush_done), 32'd1);
    @(negedge clk);
    chk("flush_done_pulse", 32'(cif.flush_done), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] hit;
    int          lat;
    int          g;

    rst           = 1'b1;
    cif.req_valid = 1'b0;
    cif.req_addr  = '0;
    cif.req_we    = 1'b0;
    cif.req_wstrb = '0;
    cif.req_wdata = '0;
    cif.flush     = 1'b0;
    mem[int'(16'h0040)] = 32'hDEADBEEF;

    repeat (3) @(negedge clk);
    chk("rst_req_ready",  32'(cif.req_ready),     32'd0);
    chk("rst_mem_valid",  32'(mif.mem_req_valid), 32'd0);
    chk("rst_rsp_valid",  32'(cif.rsp_valid),     32'd0);
    chk("rst_flush_done", 32'(cif.flush_done),    32'd0);
    rst = 1'b0;
    #1 chk("idle_req_ready", 32'(cif.req_ready), 32'd1);

    // Cold miss then hit
    do_req(16'h0040, 1'b0, 4'h0, 32'h0, rd, hit, lat);
    chk("cold_rdata", rd, 32'hDEADBEEF);
    chk("cold_hit",   hit, 32'd0);
    chk("cold_nev",   32'(ev_q.size()), 32'd1);
    chk("cold_rd_we", ev_we(0), 32'd0);
    chk("cold_rd_addr", ev_addr(0), 32'h0040);
    ev_q.delete();
    do_req(16'h0040, 1'b0, 4'h0, 32'h0, rd, hit, lat);
    chk("hit_rdata", rd, 32'hDEADBEEF);
    chk("hit_hit",   hit, 32'd1);
    chk("hit_lat",   32'(lat), 32'd1);

    // Byte store hit, then readback
    do_req(16'h0040, 1'b1, 4'b0001, 32'h000000AA, rd, hit, lat);
    chk("st_hit",   hit, 32'd1);
    chk("st_rdata", rd, 32'd0);
    chk("st_lat",   32'(lat), 32'd1);
    do_req(16'h0040, 1'b0, 4'h0, 32'h0, rd, hit, lat);
    chk("st_rb_rdata", rd, 32'hDEADBEAA);
    chk("st_rb_hit",   hit, 32'd1);
    chk("st_nev",      32'(ev_q.size()), 32'd0);

    // Fill way1 of set 16, then dirty eviction of way0 under backpressure
    do_req(16'h0840, 1'b0, 4'h0, 32'h0, rd, hit, lat);
    chk("w1_rdata", rd, 32'hA5A50840);
    chk("w1_hit",   hit, 32'd0);
    chk("w1_nev",   32'(ev_q.size()), 32'd1);
    ev_q.delete();
    ready_delay = 5;
    stab_err    = 0;
    do_req(16'h1040, 1'b0, 4'h0, 32'h0, rd, hit, lat);
    ready_delay = 0;
    chk("ev_rdata",   rd, 32'hA5A51040);
    chk("ev_hit",     hit, 32'd0);
    chk("ev_lat",     32'(lat), 32'd14);
    chk("ev_stable",  32'(stab_err), 32'd0);
    chk("ev_nev",     32'(ev_q.size()), 32'd2);
    chk("ev_wb_we",   ev_we(0), 32'd1);
    chk("ev_wb_addr", ev_addr(0), 32'h0040);
    chk("ev_wb_data", ev_data(0), 32'hDEADBEAA);
    chk("ev_rf_we",   ev_we(1), 32'd0);
    chk("ev_rf_addr", ev_addr(1), 32'h1040);
    ev_q.delete();
    // lru now names way1 (0x0840, clean); refill returns the written-back word
    do_req(16'h0040, 1'b0, 4'h0, 32'h0, rd, hit, lat);
    chk("refetch_rdata", rd, 32'hDEADBEAA);
    chk("refetch_hit",   hit, 32'd0);
    chk("refetch_nowb",  ev_we(0), 32'd0);

    // Dirty three lines in sets 1, 2, 16 and flush
    do_req(16'h0004, 1'b1, 4'b1111, 32'h11223344, rd, hit, lat);
    do_req(16'h0008, 1'b1, 4'b0110, 32'hAABBCCDD, rd, hit, lat);
    chk("st_miss_hit", hit, 32'd0);
    do_req(16'h0040, 1'b1, 4'b1000, 32'h77000000, rd, hit, lat);
    chk("st_w1_hit", hit, 32'd1);
    ev_q.delete();
    do_flush(lat);
    chk("fl_lat",    32'(lat), 32'd67);
    chk("fl_nev",    32'(ev_q.size()), 32'd3);
    chk("fl0_addr",  ev_addr(0), 32'h0004);
    chk("fl0_data",  ev_data(0), 32'h11223344);
    chk("fl1_addr",  ev_addr(1), 32'h0008);
    chk("fl1_data",  ev_data(1), 32'hA5BBCC08);
    chk("fl2_we",    ev_we(2),   32'd1);
    chk("fl2_addr",  ev_addr(2), 32'h0040);
    chk("fl2_data",  ev_data(2), 32'h77ADBEAA);
    ev_q.delete();
    do_flush(lat);
    chk("fl2nd_lat", 32'(lat), 32'd64);
    chk("fl2nd_nev", 32'(ev_q.size()), 32'd0);
    do_req(16'h0004, 1'b0, 4'h0, 32'h0, rd, hit, lat);
    chk("postfl_hit",   hit, 32'd1);
    chk("postfl_rdata", rd, 32'h11223344);

    // Reset while waiting for refill data
    hold_rsp = 1'b1;
    wait_idle();
    cif.req_valid = 1'b1;
    cif.req_addr  = 16'h0100;
    cif.req_we    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cif.req_valid = 1'b0;
    g = 0;
    while (ev_q.size() == 0 && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("rstw_fill_req", 32'(ev_q.size()), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstw_mem_valid", 32'(mif.mem_req_valid), 32'd0);
    chk("rstw_req_ready", 32'(cif.req_ready),     32'd0);
    repeat (2) @(negedge clk);
    chk("rstw_no_rsp",    32'(cif.rsp_valid),     32'd0);
    hold_rsp = 1'b0;
    rst      = 1'b0;
    ev_q.delete();
    do_req(16'h0100, 1'b0, 4'h0, 32'h0, rd, hit, lat);
    chk("rstw_miss_hit",   hit, 32'd0);
    chk("rstw_miss_rdata", rd, 32'hA5A50100);
    do_req(16'h0004, 1'b0, 4'h0, 32'h0, rd, hit, lat);
    chk("rstw_mem_hit",   hit, 32'd0);
    chk("rstw_mem_rdata", rd, 32'h11223344);

    // Store with no strobes still dirties the line
    do_req(16'h0100, 1'b1, 4'b0000, 32'hFFFFFFFF, rd, hit, lat);
    chk("st0_hit", hit, 32'd1);
    ev_q.delete();
    do_flush(lat);
    chk("st0_fl_lat",  32'(lat), 32'd65);
    chk("st0_fl_nev",  32'(ev_q.size()), 32'd1);
    chk("st0_fl_addr", ev_addr(0), 32'h0100);
    chk("st0_fl_data", ev_data(0), 32'hA5A50100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_wb2.md
# dcache_wb2

Parametrised two-way set-associative, write-back, write-allocate data cache between the CPU load/store unit and data memory. It generalises address width, data width and set count. It adds byte-strobe write merging, a ready/valid memory handshake in place of a fixed read delay, and a full-cache flush. One word per line, one outstanding request.

## Interface
- ADDR_W, 16, byte address width
- DATA_W, 32, word width; multiple of 8
- SETS, 32, number of sets; power of two, ≥2
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  CPU request valid
- req_ready  out  1  cache accepts request (IDLE only)
- req_addr  in  ADDR_W  byte address; low OFF_W bits ignored
- req_we  in  1  1 = store, 0 = load
- req_wstrb  in  DATA_W/8  store byte enables
- req_wdata  in  DATA_W  store data, lane-aligned
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_W  load data; 0 for stores
- rsp_hit  out  1  1 if the request hit, qualified by rsp_valid
- flush  in  1  write back all dirty lines (sampled in IDLE)
- flush_done  out  1  one-cycle pulse when flush completes
- mem_req_valid, mem_req_ready  out/in  1  memory request handshake
- mem_req_we  out  1  1 = write-back, 0 = refill read
- mem_req_addr  out  ADDR_W  word-aligned address (offset bits 0)
- mem_req_wdata  out  DATA_W  write-back data
- mem_rsp_valid  in  1  refill data valid
- mem_rsp_rdata  in  DATA_W  refill data

## Operation
- Address fields: OFF_W = log2(DATA_W/8); IDX_W = log2(SETS); TAG_W = ADDR_W − IDX_W − OFF_W. The index sits directly above the offset.
- Per set: valid, dirty and tag for each way. One lru bit per set, naming the way to evict next.
- States: IDLE, WB, FILL_REQ, FILL_WAIT, RESP, FL_SCAN, FL_WB.
- IDLE: req_ready = 1.
  - flush has priority over req_valid. When both are high, the flush is taken and req_ready drops.
- Hit (accept cycle): data is read, or the store is merged bytewise using req_wstrb.
  - A store sets dirty.
  - lru points to the other way.
  - Next state: RESP.
- Miss: victim selection order is invalid way0, then invalid way1, then the lru way.
  - If the victim is valid and dirty, go to WB. Otherwise go to FILL_REQ.
  - The request (addr, we, wstrb, wdata) is latched at acceptance.
- WB: mem_req_valid=1, we=1, address = {victim tag, index, 0}, data = victim data. On ready, go to FILL_REQ.
- FILL_REQ: mem_req_valid=1, we=0, address = {tag, index, 0}. On ready, go to FILL_WAIT.
- FILL_WAIT: on mem_rsp_valid, install the line.
  - Tag and valid are set; lru points to the other way.
  - Load: line = mem_rsp_rdata, dirty=0.
  - Store: line = refill merged with the strobed bytes, dirty=1.
  - Next state: RESP.
- RESP: rsp_valid=1 for one cycle. rsp_hit is set for hits and cleared for misses. Return to IDLE.
- Store with req_wstrb=0: treated as a normal store. No bytes change, but dirty is still set.
- Flush: scan (set, way) from (0,0) to (SETS−1,1).
  - Each valid and dirty line is written back through FL_WB, then its dirty bit is cleared. The valid bit is kept.
  - After the last entry, flush_done pulses and the block returns to IDLE.
- mem_req_* hold stable while mem_req_valid=1 and ready=0.
- mem_rsp_valid outside FILL_WAIT is ignored.

## Timing
- Reset: all valid, dirty and lru bits cleared; the data arrays are not required to be cleared.
- All outputs read 0 during reset, including req_ready. State is IDLE.
- Reset mid-operation aborts the operation immediately: mem_req_valid drops, with no response and no flush_done.
- Hit latency: accept at cycle 0, rsp_valid at cycle 1. Back-to-back hits complete every 2 cycles.
- Clean miss: accept, then FILL_REQ (≥1 cycle), then FILL_WAIT, then RESP. Minimum 4 cycles from accept to rsp_valid when ready and response each come in 1 cycle.
- A dirty miss adds ≥1 cycle for WB.
- Flush cost: one cycle per scanned entry, plus the handshake cycles for each dirty write-back.

## Structure
- Package dcache_wb2_pkg holds:
  - the state enum;
  - the helper functions off_w, idx_w and tag_w;
  - a byte-merge function (old, new, strb).
- One sub-module, dcache_wb2_way: the valid/dirty/tag/data arrays for one way, with a tag-compare hit output. It is instantiated twice. lru and the FSM stay in the top module.

## Test plan
- Reset, then load 0x0040 (cold miss): a read at 0x0040 is issued and memory returns 0xDEADBEEF. Required: rsp_rdata=0xDEADBEEF, rsp_hit=0. The same load then hits in 1 cycle with the same data.
- Store 0x0040 with wdata=0x000000AA, wstrb=0001 after the fill above. A following load returns 0xDEADBEAA with rsp_hit=1, and no memory write occurs.
- Conflict eviction, with defaults: lines 0x0040, 0x0840 and 0x1040 map to index 16. Dirty 0x0040, then touch 0x0840, then access 0x1040. Required: write-back to 0x0040 with the dirty data, then a refill read of 0x1040.
- Backpressure: hold mem_req_ready=0 for 5 cycles during WB. mem_req_addr and mem_req_wdata must stay stable, with no response until the handshake completes.
- Flush: dirty 3 lines across different sets, then pulse flush. Required: exactly 3 memory writes in ascending (set, way) order, then flush_done. A second flush issues no writes.
- Assert rst during FILL_WAIT. mem_req_valid=0 and req_ready=0 immediately. After release, a load to the same address misses.
